// File: rtl/line_window.sv
// Vertical window builder: keeps filter_size-1 padded lines and emits one filter_size-pixel column per accepted pixel.
// Latency: 1 cycle from input accept to o_TDATA/o_TVALID; full throughput of 1 pixel per cycle.
// Backpressure: single output register, o_TREADY = !o_TVALID || i_TREADY; output is held while stalled.
module line_window #(
    parameter int pix_depth   = 4,
    parameter int frame_width = 10,
    parameter int filter_size = 5,
    parameter int add_cells   = (filter_size - 1) / 2,
    parameter int line_width  = frame_width + 2 * add_cells
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic [pix_depth-1:0]               i_TDATA,
    input  logic                               i_TVALID,
    output logic                               o_TREADY,
    input  logic [1:0]                         i_TUSER,
    output logic [pix_depth*filter_size-1:0]   o_TDATA,
    output logic                               o_TVALID,
    input  logic                               i_TREADY,
    output logic [1:0]                         o_TUSER,
    output logic                               o_err
);

    localparam int CW = $clog2(line_width);
    localparam int RW = $clog2(filter_size);
    localparam logic [CW-1:0] COL_LAST = CW'(line_width - 1);
    localparam logic [RW-1:0] ROW_FULL = RW'(filter_size - 1);

    logic [pix_depth-1:0] line_mem [filter_size-1][line_width];

    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic          sof_pending;

    logic                             accept;
    logic                             sof;
    logic                             eol;
    logic [CW-1:0]                    c_eff;
    logic [RW-1:0]                    row_eff;
    logic                             col_valid;
    logic                             col_last;
    logic [pix_depth*filter_size-1:0] col_dat;

    assign o_TREADY  = !o_TVALID || i_TREADY;
    assign accept    = i_TVALID && o_TREADY;
    assign sof       = i_TUSER[0];
    assign eol       = i_TUSER[1];
    // A start-of-frame beat is forced to column 0, row 0 regardless of where the counters were.
    assign c_eff     = sof ? '0 : col_cnt;
    assign row_eff   = sof ? '0 : row_cnt;
    assign col_valid = (row_eff == ROW_FULL);
    assign col_last  = (c_eff == COL_LAST);

    always_comb begin
        col_dat = '0;
        col_dat[pix_depth-1:0] = i_TDATA;
        for (int k = 0; k < filter_size - 1; k++) begin
            col_dat[(k+1)*pix_depth +: pix_depth] = line_mem[k][c_eff];
        end
    end

    // Line memories shift down one row per accept at the current column; no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_mem[0][c_eff] <= i_TDATA;
            for (int k = 1; k < filter_size - 1; k++) begin
                line_mem[k][c_eff] <= line_mem[k-1][c_eff];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_TVALID    <= 1'b0;
            o_TDATA     <= '0;
            o_TUSER     <= 2'b00;
            o_err       <= 1'b0;
            col_cnt     <= '0;
            row_cnt     <= '0;
            sof_pending <= 1'b0;
        end else if (accept) begin
            o_TDATA  <= col_dat;
            o_TVALID <= col_valid;
            o_TUSER  <= {col_last, col_valid && sof_pending};
            if (col_last) begin
                col_cnt <= '0;
                row_cnt <= (row_eff == ROW_FULL) ? row_eff : row_eff + RW'(1);
            end else begin
                col_cnt <= c_eff + CW'(1);
                row_cnt <= row_eff;
            end
            if (sof) begin
                o_err       <= 1'b0;
                sof_pending <= 1'b1;
            end else begin
                if (eol != col_last) begin
                    o_err <= 1'b1;
                end
                if (col_valid) begin
                    sof_pending <= 1'b0;
                end
            end
        end else if (i_TREADY) begin
            o_TVALID <= 1'b0;
        end
    end

endmodule
